alu_mdu_seq: RTL and testbench

Parametrised next-generation execution unit for the multi-cycle RISC-V core. It combines the base integer ALU operations with RV32M/RV64M multiply and divide. A valid/ready handshake sits on both the request and result sides. Base ops return in 1 cycle. MUL/DIV ops run on an iterative radix-2 datapath, so the block can stall the pipeline via in_ready.

---
 rtl/alu_mdu_seq.sv | 108 ++++++++++
 tb/tb_alu_mdu_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: integer ALU plus iterative radix-2 multiply/divide behind valid/ready handshakes.
module alu_mdu_seq #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int SW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, MUL, DIV, HOLD} state_t;
    state_t state, state_nx;
    logic [2*XLEN-1:0] acc, acc_nx, mul_step, div_step, mul_p;
    logic [XLEN-1:0] opd, alu_res, special, abs_a, abs_b, m_a, m_b, div_diff, quo, rem, step_res;
    logic [XLEN:0] mul_sum, div_sh;
    logic [SW-1:0] cnt;
    logic neg_q, neg_r, sel, accept, last, is_m, is_mul, is_div, div_zero, div_ovf, div_go;
    logic sgn_a, sgn_b, div_ge;
    assign in_ready  = !flush && (state == IDLE || (state == HOLD && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = state == HOLD;
    assign busy      = state == MUL || state == DIV;
    assign last      = cnt == SW'(XLEN - 1);
    assign is_m      = ENABLE_M && op >= 5'd10 && op <= 5'd17;
    assign is_mul    = is_m && op <= 5'd13;
    assign is_div    = is_m && op >= 5'd14;
    assign div_zero  = b == '0;
    assign div_ovf   = !op[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
    assign div_go    = is_div && !div_zero && !div_ovf;
    assign special   = div_zero ? (op[4:1] == 4'd7 ? '1 : a) : (op[4] ? '0 : a);
    // Operands are reduced to magnitudes; the sign is restored after the iteration.
    assign sgn_a     = (is_mul && (op == 5'd11 || op == 5'd12)) || (is_div && !op[0]);
    assign sgn_b     = (is_mul && op == 5'd11) || (is_div && !op[0]);
    assign abs_a     = a[XLEN-1] ? -a : a;
    assign abs_b     = b[XLEN-1] ? -b : b;
    assign m_a       = sgn_a ? abs_a : a;
    assign m_b       = sgn_b ? abs_b : b;
    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
    assign mul_step  = {mul_sum, acc[XLEN-1:1]};
    assign div_sh    = acc[2*XLEN-1:XLEN-1];
    assign div_ge    = div_sh >= {1'b0, opd};
    assign div_diff  = div_sh[XLEN-1:0] - opd;
    assign div_step  = {div_ge ? div_diff : div_sh[XLEN-1:0], acc[XLEN-2:0], div_ge};
    assign acc_nx    = state == MUL ? mul_step : div_step;
    assign mul_p     = neg_q ? -mul_step : mul_step;
    assign quo       = neg_q ? -div_step[XLEN-1:0] : div_step[XLEN-1:0];
    assign rem       = neg_r ? -div_step[2*XLEN-1:XLEN] : div_step[2*XLEN-1:XLEN];
    assign step_res  = state == MUL ? (sel ? mul_p[2*XLEN-1:XLEN] : mul_p[XLEN-1:0]) : (sel ? rem : quo);
    always_comb begin
        alu_res = '0;
        case (op)
            5'd0:    alu_res = a + b;
            5'd1:    alu_res = a - b;
            5'd2:    alu_res = a & b;
            5'd3:    alu_res = a | b;
            5'd4:    alu_res = a ^ b;
            5'd5:    alu_res = a << b[SW-1:0];
            5'd6:    alu_res = a >> b[SW-1:0];
            5'd7:    alu_res = $unsigned($signed(a) >>> b[SW-1:0]);
            5'd8:    alu_res = XLEN'($signed(a) < $signed(b));
            5'd9:    alu_res = XLEN'(a < b);
            default: alu_res = (is_div && !div_go) ? special : '0;
        endcase
    end
    always_comb begin
        state_nx = state;
        if (flush) state_nx = IDLE;
        else if (accept) state_nx = is_mul ? MUL : (div_go ? DIV : HOLD);
        else if (busy) state_nx = last ? HOLD : state;
        else if (state == HOLD && out_ready) state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            result <= '0;
            acc    <= '0;
            opd    <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            sel    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                acc   <= {{XLEN{1'b0}}, is_mul ? m_b : m_a};
                opd   <= is_mul ? m_a : m_b;
                cnt   <= '0;
                neg_q <= (sgn_a && a[XLEN-1]) ^ (sgn_b && b[XLEN-1]);
                neg_r <= sgn_a && a[XLEN-1];
                sel   <= is_mul ? op != 5'd10 : op[4];
                if (!is_mul && !div_go) result <= alu_res;
            end else if (busy) begin
                acc <= acc_nx;
                cnt <= cnt + SW'(1);
                if (last && !flush) result <= step_res;
            end
        end
    end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb_alu_mdu_seq: scoreboard bench for alu_mdu_seq at XLEN=32.
module tb_alu_mdu_seq;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, busy;
    logic [4:0] op = '0;
    logic [31:0] a = '0, b = '0, result;
    int checks = 0, errors = 0;
    logic [31:0] exp_q[$];
    typedef struct {
        logic [4:0]  o;
        logic [31:0] x, y, e;
        int          l;
    } vec_t;

    always #5 clk = ~clk;

    alu_mdu_seq #(.XLEN(32), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    function automatic logic [31:0] ref_m(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy;
        logic [63:0] p;
        logic signed [31:0] qx, qy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        qx = x;
        qy = y;
        if (o >= 5'd14 && y == 32'd0) return (o <= 5'd15) ? 32'hFFFF_FFFF : x;
        if ((o == 5'd14 || o == 5'd16) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return (o == 5'd14) ? x : 32'd0;
        case (o)
            5'd10: p = {32'd0, x} * {32'd0, y};
            5'd11: p = sx * sy;
            5'd12: p = sx * $signed({32'd0, y});
            5'd13: p = {32'd0, x} * {32'd0, y};
            5'd14: p = {32'd0, 32'(qx / qy)};
            5'd15: p = {32'd0, x / y};
            5'd16: p = {32'd0, 32'(qx % qy)};
            default: p = {32'd0, x % y};
        endcase
        return (o >= 5'd11 && o <= 5'd13) ? p[63:32] : p[31:0];
    endfunction

    task automatic send(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic wait_out(output int lat, output int nb);
        lat = 1;
        nb = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) nb++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic run_vectors(input string name, input vec_t v[$]);
        int lat, nb;
        logic [31:0] e;
        foreach (v[i]) begin
            send(v[i].o, v[i].x, v[i].y, v[i].e);
            wait_out(lat, nb);
            e = exp_q.pop_front();
            checks++; if (result !== e) begin errors++; $display("FAIL %s_result op=%0d a=%h b=%h: got %h expected %h", name, v[i].o, v[i].x, v[i].y, result, e); end
            checks++; if (lat != v[i].l) begin errors++; $display("FAIL %s_latency op=%0d: got %0d expected %0d", name, v[i].o, lat, v[i].l); end
            if (v[i].l > 1) begin
                checks++; if (nb != v[i].l - 1) begin errors++; $display("FAIL %s_busy_cycles op=%0d: got %0d expected %0d", name, v[i].o, nb, v[i].l - 1); end
            end
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drop_valid op=%0d: got %b expected 0", name, v[i].o, out_valid); end
        end
    endtask

    task automatic test_alu();
        vec_t v[$];
        v.push_back(vec_t'{5'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1});
        v.push_back(vec_t'{5'd1, 32'h0, 32'h1, 32'hFFFF_FFFF, 1});
        v.push_back(vec_t'{5'd2, 32'hF0F0_FF00, 32'hFF00_F0F0, 32'hF000_F000, 1});
        v.push_back(vec_t'{5'd3, 32'hF0F0_0000, 32'h0000_F0F0, 32'hF0F0_F0F0, 1});
        v.push_back(vec_t'{5'd4, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1});
        v.push_back(vec_t'{5'd5, 32'h1, 32'h21, 32'h2, 1});
        v.push_back(vec_t'{5'd6, 32'h8000_0000, 32'h4, 32'h0800_0000, 1});
        v.push_back(vec_t'{5'd7, 32'h8000_0000, 32'h24, 32'hF800_0000, 1});
        v.push_back(vec_t'{5'd8, 32'hFFFF_FFFF, 32'h1, 32'h1, 1});
        v.push_back(vec_t'{5'd8, 32'h1, 32'hFFFF_FFFF, 32'h0, 1});
        v.push_back(vec_t'{5'd9, 32'h1, 32'hFFFF_FFFF, 32'h1, 1});
        v.push_back(vec_t'{5'd9, 32'hFFFF_FFFF, 32'h1, 32'h0, 1});
        v.push_back(vec_t'{5'd20, 32'h5, 32'h5, 32'h0, 1});
        v.push_back(vec_t'{5'd31, 32'hFFFF_FFFF, 32'h3, 32'h0, 1});
        run_vectors("alu", v);
    endtask

    task automatic test_mul();
        vec_t v[$];
        logic [4:0] o;
        logic [31:0] x, y;
        v.push_back(vec_t'{5'd11, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 33});
        v.push_back(vec_t'{5'd13, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 33});
        v.push_back(vec_t'{5'd12, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 33});
        v.push_back(vec_t'{5'd10, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 33});
        v.push_back(vec_t'{5'd11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
        for (int i = 0; i < 12; i++) begin
            o = 5'(10 + i % 4); x = $urandom; y = $urandom;
            v.push_back(vec_t'{o, x, y, ref_m(o, x, y), 33});
        end
        run_vectors("mul", v);
    endtask

    task automatic test_div();
        vec_t v[$];
        logic [4:0] o;
        logic [31:0] x, y;
        v.push_back(vec_t'{5'd14, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33});
        v.push_back(vec_t'{5'd16, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33});
        v.push_back(vec_t'{5'd15, 32'h5, 32'h0, 32'hFFFF_FFFF, 1});
        v.push_back(vec_t'{5'd17, 32'h5, 32'h0, 32'h5, 1});
        v.push_back(vec_t'{5'd14, 32'h5, 32'h0, 32'hFFFF_FFFF, 1});
        v.push_back(vec_t'{5'd16, 32'h5, 32'h0, 32'h5, 1});
        v.push_back(vec_t'{5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        v.push_back(vec_t'{5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1});
        v.push_back(vec_t'{5'd15, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 33});
        v.push_back(vec_t'{5'd17, 32'd100, 32'd7, 32'd2, 33});
        for (int i = 0; i < 12; i++) begin
            o = 5'(14 + i % 4); x = $urandom; y = (i >= 8) ? 32'($urandom_range(1, 300)) : $urandom;
            v.push_back(vec_t'{o, x, y, ref_m(o, x, y), (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) ? 1 : 33});
        end
        run_vectors("div", v);
    endtask

    task automatic test_back_to_back();
        int lat, nb;
        logic [31:0] e;
        @(negedge clk) out_ready = 1'b0;
        send(5'd0, 32'd3, 32'd4, 32'd7);
        wait_out(lat, nb);
        e = exp_q.pop_front();
        checks++; if (result !== e || lat != 1) begin errors++; $display("FAIL bp_first: got %h lat %0d expected %h lat 1", result, lat, e); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1 || result !== e) begin errors++; $display("FAIL bp_hold cycle %0d: got valid %b result %h expected 1 %h", i, out_valid, result, e); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d: got %b expected 0", i, in_ready); end
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; op = 5'd1; a = 32'd9; b = 32'd4;
        exp_q.push_back(32'd5);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = exp_q.pop_front();
        checks++; if (out_valid !== 1'b1 || result !== e) begin errors++; $display("FAIL b2b_result: got valid %b result %h expected 1 %h", out_valid, result, e); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        int seen = 0;
        send(5'd15, 32'd100, 32'd7, 32'd14);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 5'd0; a = 32'd1; b = 32'd1;
        #1;
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL flush_pre: got in_ready %b busy %b expected 0 1", in_ready, busy); end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_abort: got busy %b out_valid %b expected 0 0", busy, out_valid); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_result: got %0d valid cycles expected 0", seen); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        send(5'd10, 32'd3, 32'd5, 32'd15);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL arst_state: got busy %b out_valid %b expected 0 0", busy, out_valid); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL arst_result: got %h expected 0", result); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %b expected 1", in_ready); end
        @(negedge clk) rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL arst_no_result: got %0d valid cycles expected 0", seen); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_mul();
        test_div();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
